pll_lock_reset_seq: RTL

PLL_LOCK_RESET_SEQ -- requirements
Module: pll_lock_reset_seq

---
 rtl/pll_lock_reset_seq_pkg.sv | 22 ++
 rtl/pll_lock_reset_seq_sync_ff2.sv | 21 ++
 rtl/pll_lock_reset_seq.sv | 108 ++++++++++
 3 files changed

// File: rtl/pll_lock_reset_seq_pkg.sv
// Shared definitions for the PLL lock / reset sequencer: state encoding,
// default timing parameters and a small sizing helper.
package pll_lock_reset_seq_pkg;

    typedef logic [1:0] state_t;

    localparam state_t WAIT_LOCK   = 2'd0;
    localparam state_t STABILIZE   = 2'd1;
    localparam state_t RELEASE_MEM = 2'd2;
    localparam state_t RUN         = 2'd3;

    localparam int DEF_STABLE_CYCLES = 1024;
    localparam int DEF_CORE_DELAY    = 16;

    // Counter width that can hold max(a,b)-1; never narrower than one bit.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/pll_lock_reset_seq_sync_ff2.sv
// Two-flop synchronizer for a single asynchronous level; clears to 0 on reset.
module sync_ff2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_lock_reset_seq.sv
// Holds memory and core resets until the PLL lock has been stable, releases
// them in order, and records lock losses that happen while running.
module pll_lock_reset_seq
    import pll_lock_reset_seq_pkg::*;
#(
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int CORE_DELAY    = DEF_CORE_DELAY
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       soft_rst,
    input  logic       clr_lost,
    output logic       rst_mem,
    output logic       rst_core,
    output logic       ready,
    output logic       lock_lost,
    output logic [7:0] lock_loss_cnt,
    output logic [1:0] state_dbg
);

    localparam int CW = cnt_width(STABLE_CYCLES, CORE_DELAY);
    localparam logic [CW-1:0] STABLE_TERM = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] CORE_TERM   = CW'(CORE_DELAY - 1);

    logic          locked_s;
    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          lost_evt;

    sync_ff2 u_lock_sync (
        .clk (clk),
        .rst (rst),
        .d   (pll_locked),
        .q   (locked_s)
    );

    // Lock loss or soft reset from any active state wins over normal progress.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        lost_evt  = 1'b0;
        if (state != WAIT_LOCK && (!locked_s || soft_rst)) begin
            state_nxt = WAIT_LOCK;
            cnt_nxt   = '0;
            lost_evt  = (state == RUN) && !locked_s;
        end else begin
            case (state)
                WAIT_LOCK: begin
                    if (locked_s && !soft_rst) begin
                        state_nxt = STABILIZE;
                        cnt_nxt   = '0;
                    end
                end
                STABILIZE: begin
                    if (cnt == STABLE_TERM) begin
                        state_nxt = RELEASE_MEM;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
                RELEASE_MEM: begin
                    if (cnt == CORE_TERM) begin
                        state_nxt = RUN;
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
                RUN:     state_nxt = RUN;
                default: begin
                    state_nxt = WAIT_LOCK;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they change on the same edge as the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= WAIT_LOCK;
            cnt           <= '0;
            rst_mem       <= 1'b1;
            rst_core      <= 1'b1;
            ready         <= 1'b0;
            lock_lost     <= 1'b0;
            lock_loss_cnt <= 8'd0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            rst_mem  <= !(state_nxt == RELEASE_MEM || state_nxt == RUN);
            rst_core <= (state_nxt != RUN);
            ready    <= (state_nxt == RUN);
            if (lost_evt) begin
                lock_lost <= 1'b1;
            end else if (clr_lost) begin
                lock_lost <= 1'b0;
            end
            if (lost_evt && lock_loss_cnt != 8'd255) begin
                lock_loss_cnt <= lock_loss_cnt + 8'd1;
            end
        end
    end

    assign state_dbg = state;

endmodule
